// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULTU/MULT/DIVU/DIV) for a MIPS-style HI/LO datapath.
// One bit per cycle: accept, 32 RUN cycles, FIX sign correction, then results visible in DONE.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  state_t           state;
  logic [5:0]       cnt;
  logic             is_div_r;
  logic             neg_res_r;
  logic             neg_rem_r;
  logic             zero_div_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    neg_a;
  logic                    neg_b;
  logic [WIDTH-1:0]        mag_a;
  logic [WIDTH-1:0]        mag_b;
  logic                    accept;

  assign a_s    = a;
  assign b_s    = b;
  assign neg_a  = op[0] && (a_s < 0);
  assign neg_b  = op[0] && (b_s < 0);
  assign mag_a  = cond_neg(a, neg_a);
  assign mag_b  = cond_neg(b, neg_b);
  assign accept = start && ((state == IDLE) || (state == DONE));

  // Multiply keeps {acc,q} as the shifting product; divide keeps acc as remainder, q as quotient.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign sum     = {1'b0, acc} + (q[0] ? {1'b0, b_r} : '0);
  assign shifted = {acc, q[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_r};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // A zero divisor leaves acc = |a|, so only the quotient needs forcing to all ones.
  assign prod_fix = cond_neg_wide({acc, q}, neg_res_r);
  assign quo_fix  = zero_div_r ? '1 : cond_neg(q, neg_res_r);
  assign rem_fix  = cond_neg(acc, neg_rem_r);

  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_r   <= op[1];
      neg_res_r  <= neg_a ^ neg_b;
      neg_rem_r  <= neg_a;
      zero_div_r <= op[1] && (b == '0);
      b_r        <= mag_b;
      acc        <= '0;
      q          <= mag_a;
    end else if (state == RUN) begin
      if (is_div_r) begin
        acc <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
        acc <= sum[WIDTH:1];
        q   <= {sum[0], q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      dbz   <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          dbz   <= zero_div_r;
          if (is_div_r) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo),
    .dbz  (dbz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed);
    logic signed [31:0] sx, sy;
    logic signed [63:0] xs, ys, ps;
    logic [63:0]        pu;
    sx = x;
    sy = y;
    xs = sx;
    ys = sy;
    ed = 1'b0;
    case (o)
      2'b00: begin
        pu = {32'd0, x} * {32'd0, y};
        {eh, el} = pu;
      end
      2'b01: begin
        ps = xs * ys;
        {eh, el} = ps;
      end
      default: begin
        if (y == 32'd0) begin
          eh = x;
          el = 32'hFFFF_FFFF;
          ed = 1'b1;
        end else if (o == 2'b10) begin
          el = x / y;
          eh = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'd0;
        end else begin
          el = sx / sy;
          eh = sx % sy;
        end
      end
    endcase
  endtask

  task automatic present(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  // Called with the request already presented; returns in cycle 34 (chain) or cycle 35.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int glitch, input bit chain,
                        input logic [1:0] o2, input logic [31:0] x2, input logic [31:0] y2);
    logic [31:0] eh, el;
    logic        ed;
    int          dcount;
    bit          busy_bad;
    bit          exp_busy;
    model(o, x, y, eh, el, ed);
    dcount   = 0;
    busy_bad = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      exp_busy = (k <= 33);
      if (busy !== exp_busy) busy_bad = 1'b1;
      if (done === 1'b1) dcount++;
      if (k == 34) begin
        check({name, "_done"}, {63'd0, done}, 64'd1);
        check({name, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({name, "_lo"}, {32'd0, lo}, {32'd0, el});
        check({name, "_dbz"}, {63'd0, dbz}, {63'd0, ed});
      end
      start = (k == glitch);
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
    end
    check({name, "_busy_seq"}, {63'd0, busy_bad}, 64'd0);
    check({name, "_done_count"}, 64'(dcount), 64'd1);
    if (chain) begin
      present(o2, x2, y2);
    end else begin
      start = 1'b0;
      @(negedge clk);
      check({name, "_done_after"}, {63'd0, done}, 64'd0);
      check({name, "_hold"}, {hi, lo}, {eh, el});
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    int          dcount;
    bit          busy_bad;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_dbz", {63'd0, dbz}, 64'd0);

    // Release and request on the same half-cycle: first rising edge accepts it.
    rst_n = 1'b1;
    present(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 2'b00, 32'd0, 32'd0);

    present(2'b01, 32'hFFFF_FFFD, 32'd5);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 0, 1'b0, 2'b00, 32'd0, 32'd0);

    present(2'b11, 32'hFFFF_FFF9, 32'd2);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 2'b00, 32'd0, 32'd0);

    present(2'b10, 32'h64, 32'd0);
    run_op("divu_zero", 2'b10, 32'h64, 32'd0, 0, 1'b0, 2'b00, 32'd0, 32'd0);

    present(2'b00, 32'd2, 32'd3);
    run_op("multu_small", 2'b00, 32'd2, 32'd3, 0, 1'b0, 2'b00, 32'd0, 32'd0);

    present(2'b10, 32'd100, 32'd7);
    run_op("divu_ignore", 2'b10, 32'd100, 32'd7, 10, 1'b0, 2'b00, 32'd0, 32'd0);

    present(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_wrap", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 2'b00, 32'd0, 32'd0);

    present(2'b11, 32'h8000_0007, 32'd0);
    run_op("div_zero_neg", 2'b11, 32'h8000_0007, 32'd0, 0, 1'b0, 2'b00, 32'd0, 32'd0);

    present(2'b01, 32'hFFFF_FFF0, 32'h10);
    run_op("b2b_first", 2'b01, 32'hFFFF_FFF0, 32'h10, 0, 1'b1, 2'b10, 32'd1000, 32'd33);
    run_op("b2b_second", 2'b10, 32'd1000, 32'd33, 0, 1'b0, 2'b00, 32'd0, 32'd0);

    // Reset in cycle 15 of a multiply; outputs still hold the previous nonzero result.
    present(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_busy", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_dbz", {63'd0, dbz}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    dcount   = 0;
    busy_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
      if (busy !== 1'b0) busy_bad = 1'b1;
    end
    check("post_rst_done_count", 64'(dcount), 64'd0);
    check("post_rst_busy", {63'd0, busy_bad}, 64'd0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: rx = 32'h8000_0000;
        2: ry = 32'hFFFF_FFFF;
        3: ry = 32'($urandom_range(1, 20));
        4: ry = 32'h8000_0000;
        default: ;
      endcase
      present(ro, rx, ry);
      run_op($sformatf("rand%0d", i), ro, rx, ry, (i % 3 == 0) ? 20 : 0, 1'b0,
             2'b00, 32'd0, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, HI and LO width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port start, input, 1: request a new operation; sampled on rising clk.
REQ-005 The block SHALL have port op, input, 2: operation select, 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 The block SHALL have port a, input, 32: multiplicand or dividend.
REQ-007 The block SHALL have port b, input, 32: multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1: operation in progress.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse when hi/lo/dbz hold a new result.
REQ-010 The block SHALL have port hi, output, 32: product upper half or remainder; feeds the datapath result-select mux.
REQ-011 The block SHALL have port lo, output, 32: product lower half or quotient; feeds the datapath result-select mux.
REQ-012 The block SHALL have port dbz, output, 1: the last completed divide had b == 0.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN, FIX and DONE.
REQ-014 The FSM SHALL accept start=1 only in IDLE or DONE; start in RUN or FIX SHALL be ignored, with no effect on state, operands or outputs.
REQ-015 On acceptance (cycle 0) the block SHALL latch op, |a| and |b| (magnitudes for signed ops, raw values for unsigned) plus the result sign flags, and enter RUN.
REQ-016 RUN SHALL last exactly 32 cycles (cycles 1-32) and process one bit per cycle: shift-add for multiply, restoring shift-subtract for divide; a 6-bit iteration counter SHALL control the count.
REQ-017 FIX (cycle 33) SHALL apply sign correction: signed product negated (64-bit two's complement) if the operand signs differ; signed quotient negated if the signs differ; signed remainder takes the sign of the dividend.
REQ-018 The block SHALL load hi, lo and dbz on the transition FIX->DONE, so they are valid in cycle 34, in which done=1; done SHALL be 0 in every other cycle.
REQ-019 busy SHALL be 1 exactly in RUN and FIX (cycles 1-33) and 0 in IDLE and DONE.
REQ-020 DONE SHALL go to RUN if start=1 (back-to-back operation), otherwise to IDLE.
REQ-021 hi, lo and dbz SHALL hold their values until the next FIX->DONE transition.
REQ-022 Divide with b == 0 SHALL keep the same 34-cycle latency and give hi = a (unmodified), lo = 0xFFFFFFFF, dbz = 1.
REQ-023 Multiply SHALL always give dbz = 0.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0x00000000 (wrap, no flag).
REQ-025 Multiply results SHALL be exact 64-bit values with no overflow indication.
REQ-026 Operand inputs a, b and op SHALL be don't-care in every cycle other than acceptance.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, dbz=0, counter=0, regardless of clk.
REQ-028 A reset asserted mid-operation SHALL abandon the operation, with no done pulse after reset release.
REQ-029 The first start SHALL be accepted on the first rising clk with rst_n=1.

Verification
REQ-030 The bench SHALL cover MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly in cycle 34, hi=0xFFFFFFFE, lo=0x00000001, busy high in cycles 1-33 only.
REQ-031 The bench SHALL cover MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; and DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 The bench SHALL cover DIVU a=0x64, b=0 -> cycle 34: hi=0x64, lo=0xFFFFFFFF, dbz=1; then MULTU 2*3 -> hi=0, lo=6, dbz=0.
REQ-033 The bench SHALL cover start pulsed with different a/b in cycle 10 of a DIVU 100/7 -> ignored; result lo=14, hi=2, single done pulse.
REQ-034 The bench SHALL cover rst_n low in cycle 15 of a multiply -> outputs zero asynchronously; after release no done pulse for 40 cycles with start=0.
REQ-035 The bench SHALL cover start held in the DONE cycle -> new operation accepted with no IDLE cycle, second done exactly 34 cycles after the first.
